// File: rtl/multibyte_bla_subtractor.sv
// multibyte_bla_subtractor: byte-serial A - B - bin over NBYTES bytes, LSB first, 8-bit borrow-lookahead per byte.
// Latency: each diff byte is valid one cycle after its input handshake; done pulses after the last output handshake.
// Backpressure: one-deep output register; in_ready drops while a held diff byte is not taken.
// Optional: define SUB_COMPARE_EN to add the cmp_eq / cmp_ltu / cmp_lts compare outputs.
module multibyte_bla_subtractor #(
    parameter int NBYTES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       bin,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] a_byte,
    input  logic [7:0] b_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] diff_byte,
    output logic       out_last,
    output logic       busy,
    output logic       done,
    output logic       bout,
    output logic       zero,
    output logic       ovf
`ifdef SUB_COMPARE_EN
    ,
    output logic       cmp_eq,
    output logic       cmp_ltu,
    output logic       cmp_lts
`endif
);

    localparam int CW = $clog2(NBYTES + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_borrow;
    logic          r_zero_acc;
`ifdef SUB_COMPARE_EN
    logic          r_d7;
`endif

    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [8:0] w_bc;
    logic [7:0] w_d;
    logic       w_bo;
    logic       w_la_bor;
    logic       w_la_prop;
    logic       w_in_hs;
    logic       w_out_hs;
    logic       w_is_last;

    assign in_ready  = (r_state == S_RUN) && (!out_valid || out_ready);
    assign busy      = (r_state != S_IDLE);
    assign w_in_hs   = in_valid && in_ready;
    assign w_out_hs  = out_valid && out_ready;
    assign w_is_last = (r_cnt == LAST_IDX);

    // Borrow-lookahead: each bit's borrow-in is the OR of every lower generate
    // masked by the propagates above it, plus the incoming borrow masked by all
    // propagates below it, so no bit waits on its neighbour's result.
    always_comb begin
        w_g       = ~a_byte & b_byte;
        w_p       = ~(a_byte ^ b_byte);
        w_bc      = '0;
        w_bc[0]   = r_borrow;
        w_la_bor  = 1'b0;
        w_la_prop = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w_la_bor  = 1'b0;
            w_la_prop = 1'b1;
            for (int j = i; j >= 0; j--) begin
                w_la_bor  = w_la_bor | (w_g[j] & w_la_prop);
                w_la_prop = w_la_prop & w_p[j];
            end
            w_bc[i+1] = w_la_bor | (w_la_prop & r_borrow);
        end
        w_d  = a_byte ^ b_byte ^ w_bc[7:0];
        w_bo = w_bc[8];
    end

    // Control FSM, output register and flag capture in one sequential block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_borrow   <= 1'b0;
            r_zero_acc <= 1'b0;
            out_valid  <= 1'b0;
            diff_byte  <= 8'h00;
            out_last   <= 1'b0;
            done       <= 1'b0;
            bout       <= 1'b0;
            zero       <= 1'b0;
            ovf        <= 1'b0;
`ifdef SUB_COMPARE_EN
            r_d7       <= 1'b0;
            cmp_eq     <= 1'b0;
            cmp_ltu    <= 1'b0;
            cmp_lts    <= 1'b0;
`endif
        end else begin
            done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_RUN;
                        r_borrow   <= bin;
                        r_cnt      <= '0;
                        r_zero_acc <= 1'b1;
                        bout       <= 1'b0;
                        zero       <= 1'b0;
                        ovf        <= 1'b0;
`ifdef SUB_COMPARE_EN
                        cmp_eq     <= 1'b0;
                        cmp_ltu    <= 1'b0;
                        cmp_lts    <= 1'b0;
`endif
                    end
                end
                S_RUN: begin
                    if (w_in_hs && w_is_last) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (w_out_hs && out_last) begin
                        r_state <= S_IDLE;
                        done    <= 1'b1;
`ifdef SUB_COMPARE_EN
                        cmp_eq  <= zero;
                        cmp_ltu <= bout;
                        cmp_lts <= r_d7 ^ ovf;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // A newly accepted byte overwrites the output slot; otherwise a
            // taken byte empties it. Held bytes stay untouched.
            if (w_in_hs) begin
                diff_byte  <= w_d;
                out_valid  <= 1'b1;
                out_last   <= w_is_last;
                r_borrow   <= w_bo;
                r_zero_acc <= r_zero_acc & (w_d == 8'h00);
                r_cnt      <= r_cnt + 1'b1;
                if (w_is_last) begin
                    bout <= w_bo;
                    zero <= r_zero_acc & (w_d == 8'h00);
                    ovf  <= (a_byte[7] != b_byte[7]) && (w_d[7] != a_byte[7]);
`ifdef SUB_COMPARE_EN
                    r_d7 <= w_d[7];
`endif
                end
            end else if (w_out_hs) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multibyte_bla_subtractor.sv
// Bench for multibyte_bla_subtractor: directed operations checked against a
// whole-word arithmetic model, with a per-cycle output stream checker.
module tb_multibyte_bla_subtractor;

    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       bin;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a_byte;
    logic [7:0] b_byte;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff_byte;
    logic       out_last;
    logic       busy;
    logic       done;
    logic       bout;
    logic       zero;
    logic       ovf;
`ifdef SUB_COMPARE_EN
    logic       cmp_eq;
    logic       cmp_ltu;
    logic       cmp_lts;
`endif

    int checks   = 0;
    int failures = 0;

    logic [8:0] exp_q[$];
    logic       held_pending = 1'b0;
    logic [7:0] held_d;
    logic       held_l;

    multibyte_bla_subtractor #(.NBYTES(NB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bin       (bin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_byte    (a_byte),
        .b_byte    (b_byte),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff_byte (diff_byte),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf)
`ifdef SUB_COMPARE_EN
        ,
        .cmp_eq    (cmp_eq),
        .cmp_ltu   (cmp_ltu),
        .cmp_lts   (cmp_lts)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Whole-word model: returns {ovf, bout, diff}.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        logic [W:0] r;
        logic       ov;
        r  = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
        return {ov, r};
    endfunction

    // Output stream checker: every delivered byte must match the next expected
    // byte, and a byte that is not taken must stay unchanged.
    always @(negedge clk) begin
        if (!rst_n) begin
            held_pending <= 1'b0;
        end else begin
            if (held_pending && out_valid) begin
                check("hold_diff", {56'd0, diff_byte}, {56'd0, held_d});
                check("hold_last", {63'd0, out_last}, {63'd0, held_l});
            end
            held_pending <= out_valid && !out_ready;
            held_d       <= diff_byte;
            held_l       <= out_last;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {55'd0, out_last, diff_byte}, 64'h1FF_DEAD);
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("diff_byte", {56'd0, diff_byte}, {56'd0, e[7:0]});
                    check("out_last", {63'd0, out_last}, {63'd0, e[8]});
                end
            end
        end
    end

    task automatic do_start(input logic bi);
        start = 1'b1;
        bin   = bi;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] a, input logic [7:0] b);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        a_byte   = a;
        b_byte   = b;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!ok) check("in_handshake_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done(input logic [W+1:0] m);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check("done_timeout", 64'd0, 64'd1);
        end else begin
            check("bout", {63'd0, bout}, {63'd0, m[W]});
            check("zero", {63'd0, zero}, {63'd0, (m[W-1:0] == '0)});
            check("ovf", {63'd0, ovf}, {63'd0, m[W+1]});
            check("bytes_left", 64'(exp_q.size()), 64'd0);
`ifdef SUB_COMPARE_EN
            check("cmp_eq", {63'd0, cmp_eq}, {63'd0, (m[W-1:0] == '0)});
            check("cmp_ltu", {63'd0, cmp_ltu}, {63'd0, m[W]});
            check("cmp_lts", {63'd0, cmp_lts}, {63'd0, m[W-1] ^ m[W+1]});
`endif
            @(negedge clk);
            check("done_one_cycle", {62'd0, done, busy}, 64'd0);
            check("flags_held", {61'd0, bout, zero, ovf},
                  {61'd0, m[W], (m[W-1:0] == '0), m[W+1]});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi,
                          input bit bp, input bit glitch);
        logic [W+1:0] m;
        m = model(a, b, bi);
        do_start(bi);
        for (int i = 0; i < NB; i++) exp_q.push_back({(i == NB - 1), m[8*i +: 8]});
        for (int i = 0; i < NB; i++) begin
            if (bp && i == 1) begin
                out_ready = 1'b0;
                in_valid  = 1'b1;
                a_byte    = a[15:8];
                b_byte    = b[15:8];
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("bp_in_ready", {63'd0, in_ready}, 64'd0);
                    check("bp_out_valid", {63'd0, out_valid}, 64'd1);
                    check("bp_diff_held", {56'd0, diff_byte}, 64'h02);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
            if (glitch && i == 1) begin
                start = 1'b1;
                bin   = ~bi;
            end
            send_byte(a[8*i +: 8], b[8*i +: 8]);
            if (glitch && i == 1) start = 1'b0;
        end
        wait_done(m);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W+1:0] pm;
        rst_n     = 1'b0;
        start     = 1'b0;
        bin       = 1'b0;
        in_valid  = 1'b0;
        a_byte    = 8'h00;
        b_byte    = 8'h00;
        out_ready = 1'b1;

        // Pin the model with hand-computed results.
        pm = model(32'h5, 32'h3, 1'b0);
        check("model_case1", 64'(pm), 64'h0_0000_0002);
        pm = model(32'h0, 32'h1, 1'b0);
        check("model_case2", 64'(pm), 64'h1_FFFF_FFFF);
        pm = model(32'h8000_0000, 32'h1, 1'b0);
        check("model_case3", 64'(pm), 64'h2_7FFF_FFFF);
        pm = model(32'h1234_5678, 32'h1234_5678, 1'b1);
        check("model_case4b", 64'(pm), 64'h1_FFFF_FFFF);

        #13;
        check("reset_outputs",
              {53'd0, out_valid, in_ready, busy, done, out_last, bout, zero, ovf, diff_byte != 8'h00},
              64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic, wrap-around borrow, signed overflow, equal operands.
        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 1'b0);
        run_op(32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        run_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        // Mixed borrow chain across bytes and a positive-minus-negative overflow.
        run_op(32'h7F00_0100, 32'h80FF_01FF, 1'b0, 1'b0, 1'b0);
        // Backpressure on the first diff byte.
        run_op(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b1, 1'b0);

        // Reset in the middle of an operation.
        do_start(1'b0);
        exp_q.push_back({1'b0, 8'h02});
        exp_q.push_back({1'b0, 8'h00});
        send_byte(8'h05, 8'h03);
        send_byte(8'h00, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs",
              {53'd0, out_valid, in_ready, busy, done, out_last, bout, zero, ovf, diff_byte != 8'h00},
              64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("post_reset_idle", {61'd0, done, busy, out_valid}, 64'd0);
        end
        @(posedge clk);
        #1;

        // Fresh operation with a start pulse while busy that must be ignored.
        run_op(32'h1122_3344, 32'h0102_0304, 1'b0, 1'b0, 1'b1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
